// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential RV32M multiplier (shift-add over a shared CLA32, sign fixup pass)

// CLA32: 32-bit adder built from 4-bit carry-lookahead groups with rippled group carries
module CLA32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   logic [31:0] g, p;
   logic [32:0] c;
   assign g = a & b;
   assign p = a ^ b;
   // carries resolved four bits at a time from generate/propagate terms
   always_comb begin
      c[0] = cin;
      for (int j = 0; j < 32; j += 4) begin
         c[j+1] = g[j] | (p[j] & c[j]);
         c[j+2] = g[j+1] | (p[j+1] & g[j]) | (p[j+1] & p[j] & c[j]);
         c[j+3] = g[j+2] | (p[j+2] & g[j+1]) | (p[j+2] & p[j+1] & g[j])
                | (p[j+2] & p[j+1] & p[j] & c[j]);
         c[j+4] = g[j+3] | (p[j+3] & g[j+2]) | (p[j+3] & p[j+2] & g[j+1])
                | (p[j+3] & p[j+2] & p[j+1] & g[j]) | (p[j+3] & p[j+2] & p[j+1] & p[j] & c[j]);
      end
   end
   assign sum  = p ^ c[31:0];
   assign cout = c[32];
endmodule

module alu_mul_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);
   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
   state_t state, state_nx;
   logic [1:0]  op_r;
   logic        neg, accept, sa, sb, fix;
   logic [31:0] m, hi, lo;
   logic [4:0]  cnt;
   logic [31:0] add_a, add_b, add_sum, nlo;
   logic        add_cin, add_c, nlo_c;
   assign accept = start & (state == IDLE || state == DONE);
   assign sa     = a[31] & (op == 2'b01 || op == 2'b10);
   assign sb     = b[31] & (op == 2'b01);
   assign fix    = state == FIXUP;
   // the accumulate adder doubles as the upper half of the 64-bit negation during fixup
   assign add_a   = fix ? ~hi : hi;
   assign add_b   = fix ? 32'd0 : m;
   assign add_cin = fix & nlo_c;
   CLA32 u_add (.a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum), .cout(add_c));
   CLA32 u_nlo (.a(~lo), .b(32'd0), .cin(1'b1), .sum(nlo), .cout(nlo_c));
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   // next state and status outputs
   always_comb begin
      state_nx = state;
      busy     = state == CALC || state == FIXUP;
      done     = state == DONE;
      case (state)
         IDLE:  state_nx = start ? CALC : IDLE;
         CALC:  state_nx = cnt == 5'd31 ? FIXUP : CALC;
         FIXUP: state_nx = DONE;
         DONE:  state_nx = start ? CALC : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // operand capture, shift-add iterations and sign fixup
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op_r   <= '0;
         neg    <= 1'b0;
         m      <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         result <= '0;
      end else if (accept) begin
         op_r <= op;
         neg  <= sa ^ sb;
         m    <= sa ? -a : a;
         lo   <= sb ? -b : b;
         hi   <= '0;
         cnt  <= '0;
      end else if (state == CALC) begin
         {hi, lo} <= lo[0] ? {add_c, add_sum, lo[31:1]} : {1'b0, hi, lo[31:1]};
         cnt      <= cnt + 5'd1;
      end else if (fix) begin
         if (neg) {hi, lo} <= {add_sum, nlo};
         result <= op_r == 2'b00 ? (neg ? nlo : lo) : (neg ? add_sum : hi);
      end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized and directed checks of alu_mul_seq against a 64-bit product model
module tb_alu_mul_seq;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] a = '0, b = '0;
   logic        busy, done;
   logic [31:0] result;
   int checks = 0, errors = 0;

   alu_mul_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
                    .busy(busy), .done(done), .result(result));

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
      logic [63:0] ex, ey, p;
      ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
      ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
      p  = ex * ey;
      return (o == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   // issues one op from a negedge, returns at the negedge where done is seen (or after 100 cycles)
   task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] o,
                        output logic [31:0] res, output int lat, output int busy_cnt,
                        output bit held, output bit d0);
      logic [31:0] prev;
      prev = result;
      a = x; b = y; op = o; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
      d0 = done; lat = 0; busy_cnt = 0; held = 1'b1;
      while (!done && lat < 100) begin
         if (busy) busy_cnt++;
         if (result !== prev) held = 1'b0;
         @(posedge clk); @(negedge clk);
         lat++;
      end
      res = result;
   endtask

   task automatic test_reset;
      #12;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b exp 0", done); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", result); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      logic [31:0] r; int lat, bc; bit held, d0;
      do_op(32'd7, 32'd6, 2'b00, r, lat, bc, held, d0);
      checks++; if (r !== 32'h2A) begin errors++; $display("FAIL basic_result: got %h exp 0000002a", r); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL basic_latency: got %0d exp 33", lat); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL basic_busy_cycles: got %0d exp 33", bc); end
      @(posedge clk); @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic_after_done: got busy=%b done=%b exp 0 0", busy, done); end
      checks++; if (result !== 32'h2A) begin errors++; $display("FAIL basic_hold: got %h exp 0000002a", result); end
   endtask

   task automatic test_corners;
      logic [31:0] ta [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h00000000};
      logic [31:0] tb [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'h00000005, 32'h00000005, 32'h80000000};
      logic [1:0]  to [8] = '{2'b11, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b00, 2'b01};
      logic [31:0] te [8] = '{32'hFFFFFFFE, 32'h00000001, 32'h00000000, 32'hFFFFFFFF,
                              32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000000};
      logic [31:0] r; int lat, bc; bit held, d0;
      for (int i = 0; i < 8; i++) begin
         do_op(ta[i], tb[i], to[i], r, lat, bc, held, d0);
         checks++;
         if (r !== te[i]) begin
            errors++;
            $display("FAIL corner_%0d: a=%h b=%h op=%0d got %h exp %h", i, ta[i], tb[i], to[i], r, te[i]);
         end
      end
   endtask

   task automatic test_ignore_start;
      logic [31:0] first; int dcount, kdone;
      first = '0; dcount = 0; kdone = 0;
      a = 32'h12345678; b = 32'h9ABCDEF0; op = 2'b01; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 5 || k == 20) begin a = $urandom; b = $urandom; op = 2'($urandom); start = 1'b1; end
         @(posedge clk); @(negedge clk);
         start = 1'b0;
         if (done) begin
            dcount++;
            if (dcount == 1) begin first = result; kdone = k; end
         end
      end
      checks++; if (dcount !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d exp 1", dcount); end
      checks++; if (kdone !== 33) begin errors++; $display("FAIL ignore_latency: got %0d exp 33", kdone); end
      checks++;
      if (first !== ref_mul(32'h12345678, 32'h9ABCDEF0, 2'b01)) begin
         errors++; $display("FAIL ignore_result: got %h exp %h", first, ref_mul(32'h12345678, 32'h9ABCDEF0, 2'b01));
      end
      checks++; if (result !== first) begin errors++; $display("FAIL ignore_hold: got %h exp %h", result, first); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] r; int lat, bc; bit held, d0;
      do_op(32'h0001_1111, 32'h0000_2222, 2'b11, r, lat, bc, held, d0);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL b2b_first: got %h exp 00000000", r); end
      do_op(32'd3, 32'd4, 2'b00, r, lat, bc, held, d0);
      checks++; if (d0 !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b exp 0", d0); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d exp 33", lat); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL b2b_busy_cycles: got %0d exp 33", bc); end
      checks++; if (r !== 32'h0000000C) begin errors++; $display("FAIL b2b_result: got %h exp 0000000c", r); end
   endtask

   task automatic test_reset_abort;
      logic [31:0] r; int lat, bc; bit held, d0;
      do_op(32'd5, 32'd9, 2'b00, r, lat, bc, held, d0);
      checks++; if (r !== 32'd45) begin errors++; $display("FAIL abort_pre: got %h exp 0000002d", r); end
      a = 32'hDEADBEEF; b = 32'h0BADF00D; op = 2'b11; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, result} !== 34'd0) begin
         errors++; $display("FAIL abort_async: got busy=%b done=%b result=%h exp 0 0 0", busy, done, result);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_idle: got busy=%b done=%b exp 0 0", busy, done); end
      do_op(32'h00010000, 32'h00010000, 2'b11, r, lat, bc, held, d0);
      checks++; if (r !== 32'h1) begin errors++; $display("FAIL abort_mulhu: got %h exp 00000001", r); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL abort_latency: got %0d exp 33", lat); end
      do_op(32'h00010000, 32'h00010000, 2'b00, r, lat, bc, held, d0);
      checks++; if (r !== 32'h0) begin errors++; $display("FAIL abort_mul: got %h exp 00000000", r); end
   endtask

   task automatic test_random;
      logic [31:0] special [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      logic [31:0] x, y, r, e; logic [1:0] o; int lat, bc; bit held, d0;
      for (int i = 0; i < 1000; i++) begin
         x = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
         y = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
         o = 2'($urandom_range(0, 3));
         e = ref_mul(x, y, o);
         do_op(x, y, o, r, lat, bc, held, d0);
         checks++;
         if (r !== e || lat !== 33 || !held) begin
            errors++;
            $display("FAIL random_%0d: a=%h b=%h op=%0d got %h lat=%0d held=%b exp %h lat=33 held=1",
                     i, x, y, o, r, lat, held, e);
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); @(negedge clk); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_corners;
      test_ignore_start;
      test_back_to_back;
      test_reset_abort;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
